// File: rtl/bridge_xbar_pkg.sv
// Shared helpers for the L2 TCDM bridge crossbar: one-hot detection and counter sizing.
package bridge_xbar_pkg;

  // Widest select vector is_onehot accepts; narrower vectors are zero-extended by the caller.
  localparam int ONEHOT_MAX_W = 64;

  function automatic int cnt_w(input int max_ot);
    return $clog2(max_ot + 1);
  endfunction

  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/bridge_ot_tracker.sv
// Outstanding-transaction tracker: counts in-flight requests to the current slave
// and decides whether a new request may be issued without breaking response order.
module bridge_ot_tracker
  import bridge_xbar_pkg::*;
#(
  parameter int N_SLAVE         = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SLAVE-1:0] dest,
  input  logic               accept,
  input  logic [N_SLAVE-1:0] r_valid,
  output logic               ok,
  output logic               rsp,
  output logic               cnt_zero,
  output logic [N_SLAVE-1:0] last_dest
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);

  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_next;
  logic [N_SLAVE-1:0] last_dest_q;

  assign cnt_zero  = (cnt_q == '0);
  assign last_dest = last_dest_q;

  // Same-slave issue keeps ordering; switching slaves must wait for a full drain.
  assign ok  = cnt_zero | ((dest == last_dest_q) & (cnt_q < CW'(MAX_OUTSTANDING)));
  assign rsp = ~cnt_zero & (|(r_valid & last_dest_q));

  always_comb begin
    cnt_next = cnt_q;
    case ({accept, rsp})
      2'b10:   cnt_next = cnt_q + CW'(1);
      2'b01:   cnt_next = cnt_q - CW'(1);
      default: cnt_next = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      last_dest_q <= '0;
    end else begin
      cnt_q <= cnt_next;
      if (accept) begin
        last_dest_q <= dest;
      end
    end
  end

endmodule

// File: rtl/addr_dec_req_bridge_ot.sv
// Request-side address decoder with outstanding tracking: one-hot slave select,
// combinational req/gnt paths, and a local error response for bad destinations.
module addr_dec_req_bridge_ot
  import bridge_xbar_pkg::*;
#(
  parameter int ID_WIDTH        = 17,
  parameter int ID              = 1,
  parameter int N_SLAVE         = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_req_i,
  input  logic [N_SLAVE-1:0]  destination_i,
  output logic                data_gnt_o,
  input  logic [N_SLAVE-1:0]  data_gnt_i,
  output logic [N_SLAVE-1:0]  data_req_o,
  output logic [ID_WIDTH-1:0] data_ID_o,
  input  logic [N_SLAVE-1:0]  data_r_valid_i,
  output logic                data_r_valid_o,
  output logic                data_r_err_o,
  output logic [N_SLAVE-1:0]  resp_sel_o,
  output logic                busy_o
);

  logic [ONEHOT_MAX_W-1:0] dest_ext;
  logic                    dest_valid;
  logic                    ok;
  logic                    rsp;
  logic                    cnt_zero;
  logic                    issue;
  logic                    accept;
  logic                    err_q;
  logic [N_SLAVE-1:0]      last_dest;

  assign dest_ext   = ONEHOT_MAX_W'(destination_i);
  assign dest_valid = is_onehot(dest_ext);
  assign issue      = data_req_i & ok & dest_valid;

  for (genvar gi = 0; gi < N_SLAVE; gi++) begin : g_req
    assign data_req_o[gi] = issue & destination_i[gi];
  end

  // Bad destinations need no slave handshake, only an idle tracker.
  always_comb begin
    data_gnt_o = 1'b0;
    if (dest_valid) begin
      data_gnt_o = issue & (|(data_gnt_i & destination_i));
    end else begin
      data_gnt_o = data_req_i & cnt_zero;
    end
  end

  assign accept = data_gnt_o & dest_valid;

  bridge_ot_tracker #(
    .N_SLAVE        (N_SLAVE),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .dest     (destination_i),
    .accept   (accept),
    .r_valid  (data_r_valid_i),
    .ok       (ok),
    .rsp      (rsp),
    .cnt_zero (cnt_zero),
    .last_dest(last_dest)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= data_gnt_o & ~dest_valid;
    end
  end

  assign data_ID_o      = ID_WIDTH'(ID);
  assign data_r_valid_o = rsp | err_q;
  assign data_r_err_o   = err_q;
  assign resp_sel_o     = last_dest;
  assign busy_o         = ~cnt_zero | err_q;

endmodule

// File: tb/tb_addr_dec_req_bridge_ot.sv
// Scoreboard bench: a transaction-level model predicts grants and queues expected responses;
// an independent monitor matches every DUT response against that queue.
module tb_addr_dec_req_bridge_ot;

  localparam int ID_WIDTH = 17;
  localparam int ID       = 1;
  localparam int N        = 16;
  localparam int MAX_OT   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                data_req_i = 1'b0;
  logic [N-1:0]        destination_i = '0;
  logic                data_gnt_o;
  logic [N-1:0]        data_gnt_i = '0;
  logic [N-1:0]        data_req_o;
  logic [ID_WIDTH-1:0] data_ID_o;
  logic [N-1:0]        data_r_valid_i = '0;
  logic                data_r_valid_o;
  logic                data_r_err_o;
  logic [N-1:0]        resp_sel_o;
  logic                busy_o;

  addr_dec_req_bridge_ot #(
    .ID_WIDTH(ID_WIDTH), .ID(ID), .N_SLAVE(N), .MAX_OUTSTANDING(MAX_OT)
  ) dut (
    .clk(clk), .rst(rst), .data_req_i(data_req_i), .destination_i(destination_i),
    .data_gnt_o(data_gnt_o), .data_gnt_i(data_gnt_i), .data_req_o(data_req_o),
    .data_ID_o(data_ID_o), .data_r_valid_i(data_r_valid_i), .data_r_valid_o(data_r_valid_o),
    .data_r_err_o(data_r_err_o), .resp_sel_o(resp_sel_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int cyc;
    bit err;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] outq[$];          // destinations of accepted, unanswered requests
  logic [N-1:0] last_acc = '0;    // most recently accepted destination
  bit           err_pend = 1'b0;  // an error grant was given last cycle

  task automatic chk(input string name, input bit good, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (good) n_pass++;
    else $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
  endtask

  task automatic step(input logic req, input logic [N-1:0] dest, input logic [N-1:0] gi,
                      input logic [N-1:0] rv, output bit granted);
    bit           valid, may, e_gnt, e_rsp, e_busy;
    logic [N-1:0] e_req;
    int           n;
    @(posedge clk); #1;
    data_req_i = req; destination_i = dest; data_gnt_i = gi; data_r_valid_i = rv;
    @(negedge clk);
    valid = ($countones(dest) == 1);
    n = outq.size();
    if (valid) begin
      may   = (n == 0) || ((dest == outq[0]) && (n < MAX_OT));
      e_req = (req && may) ? dest : '0;
      e_gnt = req && may && ((gi & dest) != '0);
    end else begin
      e_req = '0;
      e_gnt = req && (n == 0);
    end
    e_busy = (n != 0) || err_pend;
    chk("gnt_o", data_gnt_o === e_gnt, 32'(data_gnt_o), 32'(e_gnt));
    chk("req_o", data_req_o === e_req, 32'(data_req_o), 32'(e_req));
    chk("busy_o", busy_o === e_busy, 32'(busy_o), 32'(e_busy));
    chk("resp_sel_o", resp_sel_o === last_acc, 32'(resp_sel_o), 32'(last_acc));
    e_rsp = (n != 0) && ((rv & outq[0]) != '0);
    if (e_rsp || err_pend) sb.push_back('{cyc: cyc, err: err_pend});
    if (e_rsp) void'(outq.pop_front());
    if (e_gnt && valid) begin
      outq.push_back(dest);
      last_acc = dest;
    end
    err_pend = e_gnt && !valid;
    granted  = e_gnt;
    $display("cyc=%0d req=%0b dest=%04h gnt_i=%04h rv_i=%04h -> gnt_o=%0b req_o=%04h rv_o=%0b err_o=%0b ot=%0d",
             cyc, req, dest, gi, rv, data_gnt_o, data_req_o, data_r_valid_o, data_r_err_o, outq.size());
  endtask

  // Response monitor: every DUT response must match the oldest expectation for this cycle.
  initial begin
    forever begin
      @(negedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("r_valid_missing", 1'b0, 32'(0), 32'(1));
        void'(sb.pop_front());
      end
      if (data_r_valid_o) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          chk("r_valid_unexpected", 1'b0, 32'(1), 32'(0));
        end else begin
          chk("r_err_o", data_r_err_o === sb[0].err, 32'(data_r_err_o), 32'(sb[0].err));
          void'(sb.pop_front());
        end
      end else if (data_r_err_o) begin
        chk("r_err_without_valid", 1'b0, 32'(1), 32'(0));
      end
    end
  end

  task automatic async_reset();
    @(posedge clk); #1;
    data_req_i = 1'b0; data_r_valid_i = '0; data_gnt_i = '0;
    #2 rst = 1'b1;
    #1;
    chk("busy_after_async_rst", busy_o === 1'b0, 32'(busy_o), 32'(0));
    chk("sel_after_async_rst", resp_sel_o === '0, 32'(resp_sel_o), 32'(0));
    chk("rv_after_async_rst", data_r_valid_o === 1'b0, 32'(data_r_valid_o), 32'(0));
    outq.delete(); sb.delete(); err_pend = 1'b0; last_acc = '0;
    @(negedge clk); #3 rst = 1'b0;
  endtask

  bit           g;
  bit           active;
  logic [N-1:0] hdest, rgi, rrv;

  initial begin
    #2;
    chk("rst_gnt_o", data_gnt_o === 1'b0, 32'(data_gnt_o), 32'(0));
    chk("rst_req_o", data_req_o === '0, 32'(data_req_o), 32'(0));
    chk("rst_rv_o", data_r_valid_o === 1'b0, 32'(data_r_valid_o), 32'(0));
    chk("rst_busy_o", busy_o === 1'b0, 32'(busy_o), 32'(0));
    chk("rst_ID_o", data_ID_o === ID_WIDTH'(ID), 32'(data_ID_o), 32'(ID));
    @(negedge clk); #3 rst = 1'b0;

    // Accepts up to the limit, stall when full, release after one response.
    for (int i = 0; i < 4; i++) step(1, 16'h0004, 16'h0004, '0, g);
    step(1, 16'h0004, 16'h0004, '0, g);
    step(1, 16'h0004, 16'h0004, 16'h0004, g);
    step(1, 16'h0004, 16'h0004, '0, g);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 16'h0004, g);

    // Destination switch waits for a full drain plus one cycle.
    step(1, 16'h0004, 16'h0004, '0, g);
    step(1, 16'h0004, 16'h0004, '0, g);
    step(1, 16'h0010, 16'h0010, '0, g);
    step(1, 16'h0010, 16'h0010, 16'h0004, g);
    step(1, 16'h0010, 16'h0010, 16'h0004, g);
    step(1, 16'h0010, 16'h0010, '0, g);
    step(0, '0, '0, 16'h0010, g);

    // Zero-hot and multi-hot destinations get a local error response.
    step(1, 16'h0000, '0, '0, g);
    step(0, '0, '0, '0, g);
    step(1, 16'h0006, 16'h0006, '0, g);
    step(0, '0, '0, '0, g);

    // Accept and retire in one cycle; spurious response from another slave.
    step(1, 16'h0004, 16'h0004, '0, g);
    step(1, 16'h0004, 16'h0004, 16'h0004, g);
    step(0, '0, '0, 16'h0020, g);
    step(0, '0, '0, 16'h0004, g);

    // Asynchronous reset with transactions in flight; late response is spurious.
    for (int i = 0; i < 3; i++) step(1, 16'h0004, 16'h0004, '0, g);
    async_reset();
    step(0, '0, '0, 16'h0004, g);

    // Randomised traffic; requests are held until granted.
    active = 1'b0; hdest = '0;
    for (int i = 0; i < 600; i++) begin
      if (!active && ($urandom % 3 != 0)) begin
        active = 1'b1;
        case ($urandom % 8)
          0, 1:    hdest = 16'h0004;
          2, 3:    hdest = 16'h0010;
          4:       hdest = 16'h0000;
          5:       hdest = 16'h0006;
          default: hdest = N'(1) << $urandom_range(0, N - 1);
        endcase
      end
      rgi = ($urandom % 2 != 0) ? hdest : N'($urandom);
      rrv = ($urandom % 3 == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      if ($urandom % 3 == 0) rrv = rrv | last_acc;
      step(active, hdest, rgi, rrv, g);
      if (g) active = 1'b0;
    end

    step(0, '0, '0, '0, g);
    step(0, '0, '0, '0, g);
    chk("scoreboard_drained", sb.size() == 0, 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
